// File: rtl/control_unit_sequencer.sv
// Fetch/execute sequencer: owns IR, execution sub-state and flags, classifies the IR
// into one of six decoder slots and forwards that slot's controlword/constant.
module control_unit_sequencer #(
  parameter int NUM_CLASSES = 6,
  parameter int CW_WIDTH    = 33
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [31:0]                     instruction_in,
  input  logic                            mem_ready,
  input  logic [4:0]                      status_in,
  input  logic [NUM_CLASSES*CW_WIDTH-1:0] decoder_controlwords,
  input  logic [NUM_CLASSES*64-1:0]       decoder_constants,
  output logic [31:0]                     instruction,
  output logic [1:0]                      state,
  output logic [4:0]                      status,
  output logic [CW_WIDTH-1:0]             controlword,
  output logic [63:0]                     constant,
  output logic                            instruction_load,
  output logic                            halted,
  output logic [31:0]                     instruction_count
);

  typedef enum logic [1:0] {FETCH = 2'd0, EXECUTE = 2'd1, HALT = 2'd2} phase_t;

  // Fetch word: only pc_fs = 01 (PC+4).
  localparam logic [CW_WIDTH-1:0] FETCH_CW = {{(CW_WIDTH-6){1'b0}}, 6'b010000};

  phase_t      r_phase;
  logic [31:0] r_ir;
  logic [1:0]  r_state;
  logic [4:0]  r_status;
  logic [31:0] r_count;
  logic        r_halted;

  logic                w_legal;
  logic [2:0]          w_class;
  logic [CW_WIDTH-1:0] w_cw_slot [NUM_CLASSES];
  logic [63:0]         w_k_slot  [NUM_CLASSES];
  logic [CW_WIDTH-1:0] w_exec_cw;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_slot
    assign w_cw_slot[k] = decoder_controlwords[k*CW_WIDTH +: CW_WIDTH];
    assign w_k_slot[k]  = decoder_constants[k*64 +: 64];
  end

  // Priority order matters: earlier opcode groups shadow the broader later ones.
  always_comb begin
    w_legal = 1'b1;
    w_class = 3'd0;
    if (r_ir[31:26] == 6'b000101)                                     w_class = 3'd3;
    else if (r_ir[31:25] == 7'b1011010)                               w_class = 3'd4;
    else if (r_ir[31:24] == 8'b01010100)                              w_class = 3'd4;
    else if (r_ir[31:23] == 9'b110100101 || r_ir[31:23] == 9'b111100101) w_class = 3'd5;
    else if (r_ir[31:21] == 11'b11111000010 || r_ir[31:21] == 11'b11111000000) w_class = 3'd2;
    else if (r_ir[28:24] == 5'b10001 || r_ir[28:23] == 6'b100100)     w_class = 3'd1;
    else if (r_ir[27:25] == 3'b101)                                   w_class = 3'd0;
    else                                                              w_legal = 1'b0;
  end

  assign w_exec_cw = w_legal ? w_cw_slot[w_class] : '0;

  always_comb begin
    controlword      = '0;
    constant         = '0;
    instruction_load = 1'b0;
    if (!reset) begin
      case (r_phase)
        FETCH: if (mem_ready) begin
          controlword      = FETCH_CW;
          instruction_load = 1'b1;
        end
        EXECUTE: if (w_legal) begin
          controlword = w_cw_slot[w_class];
          constant    = w_k_slot[w_class];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase  <= FETCH;
      r_ir     <= '0;
      r_state  <= '0;
      r_status <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_phase)
        FETCH: if (mem_ready) begin
          r_ir    <= instruction_in;
          r_count <= r_count + 32'd1;
          r_state <= '0;
          r_phase <= EXECUTE;
        end
        EXECUTE: begin
          if (!w_legal) begin
            r_phase  <= HALT;
            r_halted <= 1'b1;
          end else begin
            if (w_exec_cw[2]) r_status <= status_in;
            if (w_exec_cw[1:0] != 2'b00) begin
              r_state <= w_exec_cw[1:0];
            end else begin
              r_state <= '0;
              r_phase <= FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign instruction       = r_ir;
  assign state             = r_state;
  assign status            = r_status;
  assign halted            = r_halted;
  assign instruction_count = r_count;

endmodule

// File: tb/tb_control_unit_sequencer.sv
// Randomized bench: an instruction-level reference model predicts every cycle's outputs
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_control_unit_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  instruction_in;
  logic         mem_ready;
  logic [4:0]   status_in;
  logic [197:0] decoder_controlwords;
  logic [383:0] decoder_constants;
  logic [31:0]  instruction;
  logic [1:0]   state;
  logic [4:0]   status;
  logic [32:0]  controlword;
  logic [63:0]  constant;
  logic         instruction_load;
  logic         halted;
  logic [31:0]  instruction_count;

  control_unit_sequencer dut (
    .clock(clock), .reset(reset), .instruction_in(instruction_in), .mem_ready(mem_ready),
    .status_in(status_in), .decoder_controlwords(decoder_controlwords),
    .decoder_constants(decoder_constants), .instruction(instruction), .state(state),
    .status(status), .controlword(controlword), .constant(constant),
    .instruction_load(instruction_load), .halted(halted),
    .instruction_count(instruction_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [32:0] cw;
    logic [63:0] k;
    logic [31:0] ir;
    logic [1:0]  st;
    logic [4:0]  sts;
    logic        ld;
    logic        hl;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Opcode groups as (mask, match, slot), earliest entry wins; -1 = illegal.
  function automatic int classify(input logic [31:0] ir);
    logic [31:0] msk [10] = '{32'hFC000000, 32'hFE000000, 32'hFF000000, 32'hFF800000,
                              32'hFF800000, 32'hFFE00000, 32'hFFE00000, 32'h1F000000,
                              32'h1F800000, 32'h0E000000};
    logic [31:0] val [10] = '{32'h14000000, 32'hB4000000, 32'h54000000, 32'hD2800000,
                              32'hF2800000, 32'hF8400000, 32'hF8000000, 32'h11000000,
                              32'h12000000, 32'h0A000000};
    int cls [10] = '{3, 4, 4, 5, 5, 2, 2, 1, 1, 0};
    for (int i = 0; i < 10; i++)
      if ((ir & msk[i]) == val[i]) return cls[i];
    return -1;
  endfunction

  always @(negedge clock) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("controlword", 64'(controlword), 64'(e.cw));
      check("constant", constant, e.k);
      check("instruction", 64'(instruction), 64'(e.ir));
      check("state", 64'(state), 64'(e.st));
      check("status", 64'(status), 64'(e.sts));
      check("instruction_load", 64'(instruction_load), 64'(e.ld));
      check("halted", 64'(halted), 64'(e.hl));
      check("instruction_count", 64'(instruction_count), 64'(e.cnt));
    end
  end

  logic [31:0] pool [12] = '{32'hB4000043, 32'hF8408041, 32'h8B020020, 32'h14000005,
                             32'h54000001, 32'hD2800021, 32'hF2A00021, 32'hF8000041,
                             32'h91000421, 32'h92400000, 32'hB5000020, 32'h00000000};

  initial begin
    int          m_ph;
    logic [31:0] m_ir, m_cnt;
    logic [1:0]  m_st;
    logic [4:0]  m_sts;
    logic [32:0] slot_cw [6];
    logic [63:0] slot_k  [6];
    logic        rst, mr;
    int          cls;
    exp_t        e;

    reset = 1'b1; mem_ready = 1'b0; instruction_in = '0; status_in = '0;
    decoder_controlwords = '0; decoder_constants = '0;
    m_ph = 0; m_ir = '0; m_cnt = '0; m_st = '0; m_sts = '0;
    repeat (2) @(posedge clock);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      #1;
      rst = (m_ph == 2 && $urandom_range(0, 5) == 0) || ($urandom_range(0, 99) == 0);
      mr  = ($urandom_range(0, 3) != 0);
      reset = rst;
      mem_ready = mr;
      instruction_in = ($urandom_range(0, 19) == 0) ? $urandom() : pool[$urandom_range(0, 11)];
      if (instruction_in == 32'h0 && $urandom_range(0, 2) != 0) instruction_in = pool[0];
      status_in = 5'($urandom());
      for (int k = 0; k < 6; k++) begin
        slot_cw[k] = {1'($urandom()), $urandom()};
        slot_cw[k][1:0] = ($urandom_range(0, 2) == 0) ? 2'($urandom()) : 2'b00;
        slot_k[k] = {$urandom(), $urandom()};
        decoder_controlwords[k*33 +: 33] = slot_cw[k];
        decoder_constants[k*64 +: 64] = slot_k[k];
      end

      cls = classify(m_ir);
      e.cw = '0; e.k = '0; e.ld = 1'b0;
      if (!rst) begin
        if (m_ph == 0 && mr) begin
          e.cw = 33'h10;
          e.ld = 1'b1;
        end else if (m_ph == 1 && cls >= 0) begin
          e.cw = slot_cw[cls];
          e.k  = slot_k[cls];
        end
      end
      e.ir = m_ir; e.st = m_st; e.sts = m_sts; e.hl = (m_ph == 2); e.cnt = m_cnt;
      q.push_back(e);

      if (rst) begin
        m_ph = 0; m_ir = '0; m_cnt = '0; m_st = '0; m_sts = '0;
      end else if (m_ph == 0) begin
        if (mr) begin
          m_ir = instruction_in; m_cnt = m_cnt + 1; m_st = 0; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (cls < 0) m_ph = 2;
        else begin
          if (slot_cw[cls][2]) m_sts = status_in;
          if (slot_cw[cls][1:0] != 0) m_st = slot_cw[cls][1:0];
          else begin m_st = 0; m_ph = 0; end
        end
      end
      @(posedge clock);
    end

    @(negedge clock);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
